scale_scheduler: RTL and testbench



---
 rtl/scale_scheduler.sv | 185 ++++++++++++++++++
 tb/tb_scale_scheduler.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scale_scheduler.sv
//------------------------------------------------------------------------------
// scale_scheduler
// Walks one frame through its image-pyramid scales. Each valid scale gets a
// config beat, its detection stream is forwarded as packed words, and a
// one-cycle pipeline clear follows. An end-of-frame marker word closes the frame.
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module scale_scheduler #(
   parameter int unsigned IMG_WIDTH      = 45,
   parameter int unsigned IMG_HEIGHT     = 45,
   parameter int unsigned FEATURE_WIDTH  = 25,
   parameter int unsigned FEATURE_HEIGHT = 25,
   parameter int unsigned SCALE_NUM      = 2,
   parameter int unsigned SCALE_STEP     = 10,
   localparam int W_X = $clog2(IMG_WIDTH) + 1,
   localparam int W_Y = $clog2(IMG_HEIGHT) + 1,
   localparam int W_S = (SCALE_NUM <= 2) ? 1 : $clog2(SCALE_NUM)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           img_done,
   output logic           load_en,
   output logic           cfg_valid,
   input  logic           cfg_ready,
   output logic [W_S-1:0] cfg_scale,
   output logic [W_X-1:0] cfg_width,
   output logic [W_Y-1:0] cfg_height,
   input  logic           det_valid,
   output logic           det_ready,
   input  logic           det_eot,
   input  logic [W_X-1:0] det_x,
   input  logic [W_Y-1:0] det_y,
   output logic           pipe_rst,
   output logic           detect_pos_valid,
   input  logic           detect_pos_ready,
   output logic           detect_pos_eot,
   output logic [31:0]    detect_pos,
   output logic           busy
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CFG   = 3'd1,
      S_SCAN  = 3'd2,
      S_FLUSH = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   // Scale 0 is usable only if the full frame can hold one detection window.
   localparam bit FIRST_OK = (SCALE_NUM >= 1) &&
                             (IMG_WIDTH >= FEATURE_WIDTH) &&
                             (IMG_HEIGHT >= FEATURE_HEIGHT);

   state_t         state;
   state_t         state_nxt;
   logic [W_S-1:0] k;
   logic [W_X-1:0] w;
   logic [W_Y-1:0] h;
   logic           out_full;
   logic           out_eot;
   logic [31:0]    out_word;

   logic           out_room;
   logic           out_drain;
   logic           det_fire;
   logic           load_det;
   logic           load_eof;
   logic           next_ok;

   // Output register can take a new word when empty or emptying this cycle.
   assign out_room  = !out_full || detect_pos_ready;
   assign out_drain = out_full && detect_pos_ready;
   assign det_fire  = (state == S_SCAN) && det_valid && out_room;
   assign load_det  = det_fire && !det_eot;
   assign load_eof  = (state == S_DONE) && out_room;

   // Next scale valid: compare against window+step so the subtraction never wraps.
   assign next_ok = ((32'(k) + 32'd1) < SCALE_NUM) &&
                    (32'(w) >= (FEATURE_WIDTH + SCALE_STEP)) &&
                    (32'(h) >= (FEATURE_HEIGHT + SCALE_STEP));

   assign detect_pos_valid = out_full;
   assign detect_pos_eot   = out_eot;
   assign detect_pos       = out_word;

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode and per-state handshake outputs.
   always_comb begin
      state_nxt  = state;
      load_en    = 1'b0;
      busy       = 1'b1;
      cfg_valid  = 1'b0;
      cfg_scale  = '0;
      cfg_width  = '0;
      cfg_height = '0;
      det_ready  = 1'b0;
      pipe_rst   = 1'b0;
      case (state)
         S_IDLE: begin
            load_en = 1'b1;
            busy    = 1'b0;
            if (img_done) begin
               state_nxt = FIRST_OK ? S_CFG : S_DONE;
            end
         end
         S_CFG: begin
            cfg_valid  = 1'b1;
            cfg_scale  = k;
            cfg_width  = w;
            cfg_height = h;
            if (cfg_ready) begin
               state_nxt = S_SCAN;
            end
         end
         S_SCAN: begin
            det_ready = out_room;
            if (det_fire && det_eot) begin
               state_nxt = S_FLUSH;
            end
         end
         S_FLUSH: begin
            pipe_rst  = 1'b1;
            state_nxt = next_ok ? S_CFG : S_DONE;
         end
         S_DONE: begin
            if (out_room) begin
               state_nxt = S_IDLE;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Scale index and scaled dimensions: restart on a new frame, step after a flush.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         k <= '0;
         w <= '0;
         h <= '0;
      end else if ((state == S_IDLE) && img_done) begin
         k <= '0;
         w <= W_X'(IMG_WIDTH);
         h <= W_Y'(IMG_HEIGHT);
      end else if ((state == S_FLUSH) && next_ok) begin
         k <= k + W_S'(1);
         w <= w - W_X'(SCALE_STEP);
         h <= h - W_Y'(SCALE_STEP);
      end
   end

   // Single-entry output register; pipe_rst deliberately does not touch it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_full <= 1'b0;
         out_eot  <= 1'b0;
         out_word <= '0;
      end else if (load_det) begin
         out_full <= 1'b1;
         out_eot  <= 1'b0;
         out_word <= {8'(k), 12'(det_y), 12'(det_x)};
      end else if (load_eof) begin
         out_full <= 1'b1;
         out_eot  <= 1'b1;
         out_word <= 32'hFFFF_FFFF;
      end else if (out_drain) begin
         out_full <= 1'b0;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_scale_scheduler.sv
//------------------------------------------------------------------------------
// tb_scale_scheduler
// Randomized frames against a scale-list / word-queue reference model, plus
// two small instances covering the skipped-scale and undersized-frame cases.
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_scale_scheduler;

   localparam int IW  = 45;
   localparam int IH  = 45;
   localparam int FW  = 25;
   localparam int FH  = 25;
   localparam int SN  = 2;
   localparam int SS  = 10;
   localparam int WX  = $clog2(IW) + 1;
   localparam int WY  = $clog2(IH) + 1;
   localparam int WS  = (SN <= 2) ? 1 : $clog2(SN);
   localparam int SN2 = 4;
   localparam int SS2 = 12;
   localparam int WS2 = (SN2 <= 2) ? 1 : $clog2(SN2);
   localparam int IW3 = 20;
   localparam int WX3 = $clog2(IW3) + 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          img_done;
   logic          load_en;
   logic          cfg_valid;
   logic          cfg_ready;
   logic [WS-1:0] cfg_scale;
   logic [WX-1:0] cfg_width;
   logic [WY-1:0] cfg_height;
   logic          det_valid;
   logic          det_ready;
   logic          det_eot;
   logic [WX-1:0] det_x;
   logic [WY-1:0] det_y;
   logic          pipe_rst;
   logic          detect_pos_valid;
   logic          detect_pos_ready;
   logic          detect_pos_eot;
   logic [31:0]   detect_pos;
   logic          busy;

   logic           img_done_b;
   logic           load_en2, cfg_valid2, det_ready2, pipe_rst2, dpv2, eot2, busy2;
   logic [WS2-1:0] cfg_scale2;
   logic [WX-1:0]  cfg_width2;
   logic [WY-1:0]  cfg_height2;
   logic [31:0]    pos2;
   logic           load_en3, cfg_valid3, det_ready3, pipe_rst3, dpv3, eot3, busy3;
   logic [0:0]     cfg_scale3;
   logic [WX3-1:0] cfg_width3;
   logic [WY-1:0]  cfg_height3;
   logic [31:0]    pos3;

   int n_cmp = 0;
   int n_err = 0;
   int ready_mode;
   int cur_k;
   int n_pipe2 = 0;
   int n_pipe3 = 0;

   logic [31:0] cfg_q[$];
   logic [32:0] out_q[$];
   logic [31:0] cfg_q2[$];
   logic [32:0] out_q2[$];
   logic [31:0] cfg_q3[$];
   logic [32:0] out_q3[$];

   bit          pend_det = 1'b0;
   bit          pend_eot = 1'b0;
   bit          prev_stall = 1'b0;
   logic [32:0] pend_word;
   logic [33:0] prev_out;

   always #5 clk = ~clk;

   scale_scheduler dut (
      .clk(clk), .rst(rst), .img_done(img_done), .load_en(load_en),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_scale(cfg_scale),
      .cfg_width(cfg_width), .cfg_height(cfg_height),
      .det_valid(det_valid), .det_ready(det_ready), .det_eot(det_eot),
      .det_x(det_x), .det_y(det_y), .pipe_rst(pipe_rst),
      .detect_pos_valid(detect_pos_valid), .detect_pos_ready(detect_pos_ready),
      .detect_pos_eot(detect_pos_eot), .detect_pos(detect_pos), .busy(busy)
   );

   scale_scheduler #(.SCALE_NUM(SN2), .SCALE_STEP(SS2)) dut_b (
      .clk(clk), .rst(rst), .img_done(img_done_b), .load_en(load_en2),
      .cfg_valid(cfg_valid2), .cfg_ready(1'b1), .cfg_scale(cfg_scale2),
      .cfg_width(cfg_width2), .cfg_height(cfg_height2),
      .det_valid(1'b1), .det_ready(det_ready2), .det_eot(1'b1),
      .det_x('0), .det_y('0), .pipe_rst(pipe_rst2),
      .detect_pos_valid(dpv2), .detect_pos_ready(1'b1),
      .detect_pos_eot(eot2), .detect_pos(pos2), .busy(busy2)
   );

   scale_scheduler #(.IMG_WIDTH(IW3)) dut_c (
      .clk(clk), .rst(rst), .img_done(img_done_b), .load_en(load_en3),
      .cfg_valid(cfg_valid3), .cfg_ready(1'b1), .cfg_scale(cfg_scale3),
      .cfg_width(cfg_width3), .cfg_height(cfg_height3),
      .det_valid(1'b1), .det_ready(det_ready3), .det_eot(1'b1),
      .det_x('0), .det_y('0), .pipe_rst(pipe_rst3),
      .detect_pos_valid(dpv3), .detect_pos_ready(1'b1),
      .detect_pos_eot(eot3), .detect_pos(pos3), .busy(busy3)
   );

   // Reference model: number of usable scales from the scaling rule.
   function automatic int n_scales(input int iw, input int ih, input int fw,
                                   input int fh, input int sn, input int ss);
      int n = 0;
      while (n < sn && (iw - n * ss) >= fw && (ih - n * ss) >= fh) n++;
      return n;
   endfunction

   function automatic logic [31:0] cfg_word(input int k, input int w, input int h);
      return {k[7:0], h[11:0], w[11:0]};
   endfunction

   function automatic logic [31:0] pos_word(input int k, input int x, input int y);
      return {k[7:0], y[11:0], x[11:0]};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Monitor sampled mid-cycle: records handshakes, checks latency, hold and pipe_rst.
   always @(negedge clk) begin
      if (!rst) begin
         pend_det   = 1'b0;
         pend_eot   = 1'b0;
         prev_stall = 1'b0;
      end else begin
         if (pend_det)
            check("det_latency", 64'({detect_pos_valid, detect_pos_eot, detect_pos}),
                  64'({1'b1, pend_word}));
         if (prev_stall)
            check("out_hold", 64'({detect_pos_valid, detect_pos_eot, detect_pos}), 64'(prev_out));
         check("pipe_rst", 64'(pipe_rst), 64'(pend_eot));
         if (detect_pos_valid && detect_pos_ready) out_q.push_back({detect_pos_eot, detect_pos});
         if (cfg_valid && cfg_ready)
            cfg_q.push_back(cfg_word(int'(cfg_scale), int'(cfg_width), int'(cfg_height)));
         pend_det   = det_valid && det_ready && !det_eot;
         pend_word  = {1'b0, pos_word(cur_k, int'(det_x), int'(det_y))};
         pend_eot   = det_valid && det_ready && det_eot;
         prev_stall = detect_pos_valid && !detect_pos_ready;
         prev_out   = {detect_pos_valid, detect_pos_eot, detect_pos};

         if (cfg_valid2) cfg_q2.push_back(cfg_word(int'(cfg_scale2), int'(cfg_width2), int'(cfg_height2)));
         if (pipe_rst2) n_pipe2++;
         if (dpv2) out_q2.push_back({eot2, pos2});
         if (cfg_valid3) cfg_q3.push_back(cfg_word(int'(cfg_scale3), int'(cfg_width3), int'(cfg_height3)));
         if (pipe_rst3) n_pipe3++;
         if (dpv3) out_q3.push_back({eot3, pos3});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      case (ready_mode)
         0:       detect_pos_ready = 1'b0;
         1:       detect_pos_ready = 1'b1;
         default: detect_pos_ready = ($urandom_range(0, 3) != 0);
      endcase
   endtask

   task automatic wait_cfg();
      int n = 0;
      while (!cfg_valid && n < 100) begin
         tick();
         n++;
      end
      check("cfg_wait", 64'(cfg_valid), 64'(1));
   endtask

   task automatic send_beat(input int x, input int y, input bit eot, input bit gaps);
      int n = 0;
      bit acc = 1'b0;
      if (gaps) repeat ($urandom_range(0, 2)) tick();
      det_valid = 1'b1;
      det_eot   = eot;
      det_x     = WX'(x);
      det_y     = WY'(y);
      while (!acc && n < 100) begin
         #1;
         acc = det_ready;
         tick();
         n++;
      end
      check("det_accept_wait", 64'(acc), 64'(1));
      det_valid = 1'b0;
      det_eot   = 1'b0;
   endtask

   // One whole frame: stimulus plus expected cfg/out sequences from the model.
   task automatic run_frame(input int rmode, input int stall, input bit fixed0,
                            input bit poke, input bit bp);
      int ns, nb, x, y, w, h, n;
      logic [32:0] exp_out[$];
      ns = n_scales(IW, IH, FW, FH, SN, SS);
      cfg_q.delete();
      out_q.delete();
      ready_mode = bp ? 0 : rmode;
      if (bp) detect_pos_ready = 1'b0;
      img_done = 1'b1;
      tick();
      img_done = 1'b0;
      for (int k = 0; k < ns; k++) begin
         w = IW - k * SS;
         h = IH - k * SS;
         cur_k = k;
         cfg_ready = (stall == 0);
         wait_cfg();
         for (int i = 0; i < stall; i++) begin
            check("cfg_hold", 64'({cfg_valid, cfg_word(int'(cfg_scale), int'(cfg_width), int'(cfg_height))}),
                  64'({1'b1, cfg_word(k, w, h)}));
            tick();
         end
         cfg_ready = 1'b1;
         tick();
         cfg_ready = 1'b0;
         nb = (fixed0 && k == 0) ? 2 : $urandom_range(1, 5);
         for (int b = 0; b < nb; b++) begin
            if (fixed0 && k == 0) begin
               x = (b == 0) ? 3 : 10;
               y = (b == 0) ? 7 : 0;
            end else begin
               x = $urandom_range(0, w - 1);
               y = $urandom_range(0, h - 1);
            end
            exp_out.push_back({1'b0, pos_word(k, x, y)});
            send_beat(x, y, 1'b0, rmode == 2);
            if (bp && k == 0 && b == 0) begin
               det_valid = 1'b1;
               for (int i = 0; i < 5; i++) begin
                  #1;
                  check("bp_det_ready", 64'(det_ready), 64'(0));
                  check("bp_hold", 64'({detect_pos_valid, detect_pos}), 64'({1'b1, pos_word(k, x, y)}));
                  tick();
               end
               det_valid = 1'b0;
               ready_mode = rmode;
               detect_pos_ready = 1'b1;
            end
         end
         if (poke && k == 0) begin
            img_done = 1'b1;
            tick();
            img_done = 1'b0;
         end
         send_beat(0, 0, 1'b1, rmode == 2);
      end
      exp_out.push_back({1'b1, 32'hFFFF_FFFF});
      n = 0;
      while (busy && n < 100) begin
         tick();
         n++;
      end
      check("frame_end_busy", 64'(busy), 64'(0));
      ready_mode = 1;
      repeat (3) tick();
      check("idle_load_en", 64'(load_en), 64'(1));
      check("cfg_count", 64'(cfg_q.size()), 64'(ns));
      for (int i = 0; i < ns && i < cfg_q.size(); i++)
         check("cfg_beat", 64'(cfg_q[i]), 64'(cfg_word(i, IW - i * SS, IH - i * SS)));
      check("out_count", 64'(out_q.size()), 64'(exp_out.size()));
      for (int i = 0; i < exp_out.size() && i < out_q.size(); i++)
         check("out_word", 64'(out_q[i]), 64'(exp_out[i]));
   endtask

   initial begin
      rst = 1'b0;
      img_done = 1'b0;
      img_done_b = 1'b0;
      cfg_ready = 1'b0;
      det_valid = 1'b0;
      det_eot = 1'b0;
      det_x = '0;
      det_y = '0;
      detect_pos_ready = 1'b1;
      ready_mode = 1;
      cur_k = 0;
      repeat (3) tick();
      check("rst_ctrl", 64'({load_en, busy, cfg_valid, det_ready, pipe_rst, detect_pos_valid, detect_pos_eot}),
            64'(7'b1000000));
      check("rst_pos", 64'(detect_pos), 64'(0));
      check("rst_cfg", 64'({cfg_scale, cfg_width, cfg_height}), 64'(0));
      rst = 1'b1;
      tick();
      check("post_rst", 64'({load_en, busy}), 64'(2'b10));

      img_done_b = 1'b1;
      tick();
      img_done_b = 1'b0;

      run_frame(1, 0, 1'b1, 1'b0, 1'b0);
      run_frame(2, 3, 1'b0, 1'b1, 1'b0);
      run_frame(1, 0, 1'b0, 1'b0, 1'b1);

      // Reset in the middle of a scan with the output register occupied.
      ready_mode = 0;
      detect_pos_ready = 1'b0;
      img_done = 1'b1;
      tick();
      img_done = 1'b0;
      cur_k = 0;
      wait_cfg();
      cfg_ready = 1'b1;
      tick();
      cfg_ready = 1'b0;
      send_beat(1, 2, 1'b0, 1'b0);
      #1;
      check("pre_rst_full", 64'(detect_pos_valid), 64'(1));
      rst = 1'b0;
      #1;
      check("rst_mid_scan", 64'({detect_pos_valid, load_en, busy, det_ready}), 64'(4'b0100));
      tick();
      rst = 1'b1;
      ready_mode = 1;
      tick();
      run_frame(1, 0, 1'b0, 1'b0, 1'b0);

      for (int f = 0; f < 4; f++) run_frame(2, $urandom_range(0, 2), 1'b0, 1'b0, 1'b0);

      check("b_cfg_count", 64'(cfg_q2.size()), 64'(n_scales(IW, IH, FW, FH, SN2, SS2)));
      for (int i = 0; i < cfg_q2.size(); i++)
         check("b_cfg_beat", 64'(cfg_q2[i]), 64'(cfg_word(i, IW - i * SS2, IH - i * SS2)));
      check("b_pipe_count", 64'(n_pipe2), 64'(n_scales(IW, IH, FW, FH, SN2, SS2)));
      check("b_out_count", 64'(out_q2.size()), 64'(1));
      check("b_eof", 64'((out_q2.size() > 0) ? out_q2[0] : 33'd0), 64'({1'b1, 32'hFFFF_FFFF}));
      check("c_cfg_count", 64'(cfg_q3.size()), 64'(n_scales(IW3, IH, FW, FH, SN, SS)));
      check("c_pipe_count", 64'(n_pipe3), 64'(0));
      check("c_out_count", 64'(out_q3.size()), 64'(1));
      check("c_eof", 64'((out_q3.size() > 0) ? out_q3[0] : 33'd0), 64'({1'b1, 32'hFFFF_FFFF}));
      check("bc_idle", 64'({load_en2, busy2, det_ready2, load_en3, busy3, det_ready3}), 64'(6'b100100));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
